accelbrot_com_byte2word: RTL

- Receive-side framer that sits between the UART byte receiver and the word-to-block deserializer.
- Hunts for a sync byte, then collects NWORDS little-endian words of WWIDTH bits each and validates padding and checksum.
- On a good frame, emits all NWORDS words as one back-to-back burst, because the downstream deserializer shifts every clock and needs words on consecutive cycles.
- Bad or stalled frames are dropped and reported by error pulses.

---
 rtl/accelbrot_com_byte2word.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/accelbrot_com_byte2word.sv
// Receive-side framer: hunts for a sync byte, collects NWORDS little-endian
// words of WWIDTH bits, validates pad bits and an additive checksum, then
// replays a good frame as a back-to-back burst of NWORDS words.
module accelbrot_com_byte2word #(
  parameter int         NWORDS         = 8,
  parameter int         WWIDTH         = 34,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic [WWIDTH-1:0] out_word,
  output logic              out_start,
  output logic              out_valid,
  output logic              err_checksum,
  output logic              err_pad,
  output logic              err_timeout
);

  localparam int BPW      = (WWIDTH + 7) / 8;
  localparam int NBYTES   = NWORDS * BPW;
  localparam int LASTBITS = WWIDTH - (BPW - 1) * 8;
  localparam int IW       = $clog2(NBYTES + 1);
  localparam int PW       = $clog2(BPW + 1);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int KW       = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  // Nonzero bits above WWIDTH in the last byte of a word are a framing fault.
  function automatic logic pad_bad(input logic [7:0] b);
    logic [7:0] mask;
    mask = 8'hFF << LASTBITS;
    return |(b & mask);
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IW-1:0]            r_idx;
  logic [PW-1:0]            r_wpos;
  logic [7:0]               r_sum;
  logic                     r_pad;
  logic [TW-1:0]            r_idle;
  logic [NBYTES*8-1:0]      r_coll;
  logic [NWORDS*WWIDTH-1:0] r_obuf;
  logic [KW-1:0]            r_bidx;

  logic                     w_frame_done;
  logic                     w_expire;
  logic                     w_good;
  logic [7:0]               w_sum_nxt;
  logic [NWORDS*WWIDTH-1:0] w_words;

  assign w_sum_nxt = r_sum + in_byte;
  assign w_good    = (w_sum_nxt == 8'h00) && !r_pad;

  // Next-state decode: sync hunt, payload count, checksum slot and idle timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (in_valid && (in_byte == SYNC_BYTE)) begin
          w_state_nxt = S_PAYLOAD;
        end else begin
          w_state_nxt = S_HUNT;
        end
      end
      S_PAYLOAD: begin
        if (in_valid) begin
          if (r_idx == IW'(NBYTES - 1)) begin
            w_state_nxt = S_CHECK;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end else if (r_idle == TW'(TIMEOUT_CYCLES - 1)) begin
          w_expire    = 1'b1;
          w_state_nxt = S_HUNT;
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_CHECK: begin
        if (in_valid) begin
          w_frame_done = 1'b1;
          w_state_nxt  = S_HUNT;
        end else if (r_idle == TW'(TIMEOUT_CYCLES - 1)) begin
          w_expire    = 1'b1;
          w_state_nxt = S_HUNT;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase
  end

  // Slice the collected bytes into words; pad bits are dropped here.
  always_comb begin
    w_words = '0;
    for (int k = 0; k < NWORDS; k++) begin
      w_words[k*WWIDTH +: WWIDTH] = r_coll[k*BPW*8 +: WWIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Collect path: byte position, checksum accumulator, sticky pad flag, idle counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idx  <= '0;
      r_wpos <= '0;
      r_sum  <= 8'h00;
      r_pad  <= 1'b0;
      r_idle <= '0;
      r_coll <= '0;
    end else if (r_state == S_HUNT) begin
      r_idle <= '0;
      if (in_valid && (in_byte == SYNC_BYTE)) begin
        r_idx  <= '0;
        r_wpos <= '0;
        r_sum  <= 8'h00;
        r_pad  <= 1'b0;
      end
    end else if (in_valid) begin
      r_idle <= '0;
      if (r_state == S_PAYLOAD) begin
        r_coll[int'(r_idx)*8 +: 8] <= in_byte;
        r_sum                      <= w_sum_nxt;
        r_idx                      <= r_idx + IW'(1);
        if (r_wpos == PW'(BPW - 1)) begin
          r_wpos <= '0;
          if (pad_bad(in_byte)) begin
            r_pad <= 1'b1;
          end
        end else begin
          r_wpos <= r_wpos + PW'(1);
        end
      end
    end else begin
      r_idle <= r_idle + TW'(1);
    end
  end

  // Burst engine: a good frame is snapshotted so the next frame can be collected meanwhile.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_obuf    <= '0;
      r_bidx    <= '0;
      out_word  <= '0;
      out_start <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_frame_done && w_good) begin
      r_obuf    <= w_words;
      out_word  <= w_words[WWIDTH-1:0];
      out_start <= 1'b1;
      out_valid <= 1'b1;
      r_bidx    <= KW'(1);
    end else if (out_valid && (r_bidx != KW'(NWORDS))) begin
      out_word  <= r_obuf[int'(r_bidx)*WWIDTH +: WWIDTH];
      out_start <= 1'b0;
      out_valid <= 1'b1;
      r_bidx    <= r_bidx + KW'(1);
    end else begin
      out_start <= 1'b0;
      out_valid <= 1'b0;
    end
  end

  // Error pulses, one cycle after the checksum byte or the expiring idle cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_checksum <= 1'b0;
      err_pad      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_checksum <= w_frame_done && (w_sum_nxt != 8'h00);
      err_pad      <= w_frame_done && r_pad;
      err_timeout  <= w_expire;
    end
  end

endmodule
